run_monitor: RTL and testbench

- Synthesizable run-completion checker for the RISC-V core; parametrised successor to the bench-only "wait for PC == end address, then check registers" flow.
- Watches the core PC for a programmable finish address and enforces a cycle timeout.
- On finish, reads up to NCHK register-file entries through a dedicated read port and compares them with expected values.
- Reports pass/timeout/mismatch status; usable in simulation and on FPGA.

---
 rtl/run_monitor_pkg.sv | 14 +
 rtl/mon_cycle_counter.sv | 39 +++
 rtl/run_monitor.sv | 162 ++++++++++++++++
 tb/tb_run_monitor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types and defaults for the run-completion monitor.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCheck,
    StDone
  } mon_state_t;

  localparam logic [31:0] FIN_ADDR_DEFAULT = 32'h0000_00bc;
  localparam int unsigned RF_AW            = 5;

endpackage

// File: rtl/mon_cycle_counter.sv
// Saturating cycle counter with clear/enable and a terminal compare against limit_i-1.
module mon_cycle_counter
  import run_monitor_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             term_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // A zero limit disables the terminal match entirely.
  assign term_o  = (limit_i != '0) && (count_q == limit_i - Width'(1));

endmodule

// File: rtl/run_monitor.sv
// Run-completion checker: waits for the finish PC or a timeout, then checks register slots.
// Define RUN_MONITOR_ALLCHK_EN to visit every slot instead of stopping at the first mismatch.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned Xlen = 32,
  parameter int unsigned Nchk = 4,
  parameter int unsigned RfAw = RF_AW,
  parameter int unsigned CntW = 32,
  localparam int unsigned IdxW = (Nchk > 1) ? $clog2(Nchk) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [Xlen-1:0]   fin_addr_i,
  input  logic [CntW-1:0]   timeout_cycles_i,
  input  logic [Xlen-1:0]   pc_i,
  input  logic [Nchk-1:0]   chk_en_i,
  input  logic [Nchk*RfAw-1:0] chk_addr_i,
  input  logic [Nchk*Xlen-1:0] chk_exp_i,
  output logic [RfAw-1:0]   rf_raddr_o,
  input  logic [Xlen-1:0]   rf_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_timeout_o,
  output logic              fail_mismatch_o,
  output logic [Nchk-1:0]   fail_vec_o,
  output logic [IdxW-1:0]   fail_idx_o,
  output logic [Xlen-1:0]   fail_got_o,
  output logic [CntW-1:0]   cycle_count_o
);

  mon_state_t      state_d, state_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic            pass_d, pass_q;
  logic            fail_timeout_d, fail_timeout_q;
  logic            fail_mismatch_d, fail_mismatch_q;
  logic [Nchk-1:0] fail_vec_d, fail_vec_q;
  logic [IdxW-1:0] fail_idx_d, fail_idx_q;
  logic [Xlen-1:0] fail_got_d, fail_got_q;

  logic            cnt_clr, cnt_en, cnt_term;
  logic [RfAw-1:0] slot_addr;
  logic [Xlen-1:0] slot_exp;
  logic            slot_bad, slot_last, check_end;

  mon_cycle_counter #(
    .Width(CntW)
  ) u_cycle_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .limit_i(timeout_cycles_i),
    .count_o(cycle_count_o),
    .term_o (cnt_term)
  );

  assign slot_addr = chk_addr_i[int'(idx_q)*RfAw +: RfAw];
  assign slot_exp  = chk_exp_i[int'(idx_q)*Xlen +: Xlen];
  assign slot_bad  = chk_en_i[idx_q] && (rf_rdata_i != slot_exp);
  assign slot_last = (idx_q == IdxW'(Nchk - 1));

`ifdef RUN_MONITOR_ALLCHK_EN
  assign check_end = slot_last;
`else
  assign check_end = slot_last | slot_bad;
`endif

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    pass_d          = pass_q;
    fail_timeout_d  = fail_timeout_q;
    fail_mismatch_d = fail_mismatch_q;
    fail_vec_d      = fail_vec_q;
    fail_idx_d      = fail_idx_q;
    fail_got_d      = fail_got_q;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d         = StRun;
          idx_d           = '0;
          pass_d          = 1'b0;
          fail_timeout_d  = 1'b0;
          fail_mismatch_d = 1'b0;
          fail_vec_d      = '0;
          fail_idx_d      = '0;
          fail_got_d      = '0;
          cnt_clr         = 1'b1;
        end
      end
      StRun: begin
        // Finish hit takes priority over a coincident timeout.
        if (pc_i == fin_addr_i) begin
          state_d = StCheck;
          idx_d   = '0;
        end else if (cnt_term) begin
          state_d        = StDone;
          fail_timeout_d = 1'b1;
          pass_d         = 1'b0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StCheck: begin
        if (slot_bad) begin
          fail_vec_d[idx_q] = 1'b1;
          fail_mismatch_d   = 1'b1;
          // Only the lowest mismatching slot is reported in idx/got.
          if (!fail_mismatch_q) begin
            fail_idx_d = idx_q;
            fail_got_d = rf_rdata_i;
          end
        end
        if (check_end) begin
          state_d = StDone;
          pass_d  = ~fail_timeout_q & ~fail_mismatch_d;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      pass_q          <= 1'b0;
      fail_timeout_q  <= 1'b0;
      fail_mismatch_q <= 1'b0;
      fail_vec_q      <= '0;
      fail_idx_q      <= '0;
      fail_got_q      <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      pass_q          <= pass_d;
      fail_timeout_q  <= fail_timeout_d;
      fail_mismatch_q <= fail_mismatch_d;
      fail_vec_q      <= fail_vec_d;
      fail_idx_q      <= fail_idx_d;
      fail_got_q      <= fail_got_d;
    end
  end

  assign rf_raddr_o      = (state_q == StCheck) ? slot_addr : '0;
  assign busy_o          = (state_q == StRun) || (state_q == StCheck);
  assign done_o          = (state_q == StDone);
  assign pass_o          = pass_q;
  assign fail_timeout_o  = fail_timeout_q;
  assign fail_mismatch_o = fail_mismatch_q;
  assign fail_vec_o      = fail_vec_q;
  assign fail_idx_o      = fail_idx_q;
  assign fail_got_o      = fail_got_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed table, hand sequences, randomized model check.
module tb_run_monitor;

`ifdef RUN_MONITOR_ALLCHK_EN
  localparam bit AllChk = 1'b1;
`else
  localparam bit AllChk = 1'b0;
`endif

  logic         clk, rst_n, start;
  logic [31:0]  fin_addr, timeout_cycles, pc;
  logic [3:0]   chk_en;
  logic [19:0]  chk_addr;
  logic [127:0] chk_exp;
  logic [4:0]   rf_raddr;
  logic [31:0]  rf_rdata;
  logic         busy, done, pass, fail_timeout, fail_mismatch;
  logic [3:0]   fail_vec;
  logic [1:0]   fail_idx;
  logic [31:0]  fail_got, cycle_count;

  logic [31:0]  rf [32];
  int           n_checks = 0;
  int           n_fail   = 0;

  typedef struct {
    logic [31:0]  fin;
    int           tmo;
    int           hit;
    int           poke;
    logic [3:0]   en;
    logic [19:0]  addr;
    logic [127:0] exp;
    bit           ow_v;
    logic [4:0]   ow_a;
    logic [31:0]  ow_d;
    bit           e_pass, e_to, e_mm;
    logic [3:0]   e_vec;
    logic [1:0]   e_idx;
    logic [31:0]  e_got;
    int           e_cnt;
    int           e_lat;
  } vec_t;

  run_monitor dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .fin_addr_i      (fin_addr),
    .timeout_cycles_i(timeout_cycles),
    .pc_i            (pc),
    .chk_en_i        (chk_en),
    .chk_addr_i      (chk_addr),
    .chk_exp_i       (chk_exp),
    .rf_raddr_o      (rf_raddr),
    .rf_rdata_i      (rf_rdata),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .fail_timeout_o  (fail_timeout),
    .fail_mismatch_o (fail_mismatch),
    .fail_vec_o      (fail_vec),
    .fail_idx_o      (fail_idx),
    .fail_got_o      (fail_got),
    .cycle_count_o   (cycle_count)
  );

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rf[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  function automatic logic [31:0] nonfin(input logic [31:0] f);
    logic [31:0] x;
    x = $urandom;
    if (x == 32'd0) x = 32'd4;
    return f ^ x;
  endfunction

  task automatic init_rf();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0100_0000 | i;
    rf[0]  = 32'd0;
    rf[10] = 32'h00ff_f05f;
    rf[2]  = 32'h0010_0000;
  endtask

  function automatic vec_t mkv(input logic [31:0] fin, input int tmo, input int hit, input int poke,
                               input logic [3:0] en, input logic [19:0] addr,
                               input logic [127:0] exp, input bit ow_v, input logic [4:0] ow_a,
                               input logic [31:0] ow_d, input bit p, input bit to, input bit mm,
                               input logic [3:0] vec, input logic [1:0] idx,
                               input logic [31:0] got, input int cnt, input int lat);
    vec_t v;
    v.fin = fin; v.tmo = tmo; v.hit = hit; v.poke = poke;
    v.en = en; v.addr = addr; v.exp = exp;
    v.ow_v = ow_v; v.ow_a = ow_a; v.ow_d = ow_d;
    v.e_pass = p; v.e_to = to; v.e_mm = mm; v.e_vec = vec; v.e_idx = idx;
    v.e_got = got; v.e_cnt = cnt; v.e_lat = lat;
    return v;
  endfunction

  // Spec-level outcome: who wins (finish vs budget), which enabled slots disagree with the RF.
  function automatic vec_t model(input vec_t v);
    vec_t       r;
    logic [3:0] bad;
    int         first;
    r = v; bad = '0; first = -1;
    r.e_pass = 0; r.e_to = 0; r.e_mm = 0; r.e_vec = '0; r.e_idx = '0; r.e_got = '0;
    if (v.hit >= 0 && (v.tmo == 0 || v.hit < v.tmo)) begin
      r.e_cnt = v.hit;
      for (int i = 0; i < 4; i++) begin
        if (v.en[i] && rd(v.addr[i*5 +: 5]) != v.exp[i*32 +: 32]) begin
          bad[i] = 1'b1;
          if (first < 0) first = i;
        end
      end
      if (first < 0) begin
        r.e_pass = 1;
        r.e_lat  = v.hit + 4;
      end else begin
        r.e_mm  = 1;
        r.e_idx = first[1:0];
        r.e_got = rd(v.addr[first*5 +: 5]);
        r.e_vec = AllChk ? bad : 4'(1 << first);
        r.e_lat = v.hit + (AllChk ? 4 : first + 1);
      end
    end else begin
      r.e_to  = 1;
      r.e_cnt = v.tmo - 1;
      r.e_lat = v.tmo - 1;
    end
    return r;
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    int k;
    bit seen;
    fin_addr       = v.fin;
    timeout_cycles = 32'(v.tmo);
    chk_en         = v.en;
    chk_addr       = v.addr;
    chk_exp        = v.exp;
    pc             = nonfin(v.fin);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".armed"}, {busy, done, pass, fail_timeout, fail_mismatch, fail_vec, cycle_count},
        {1'b1, 4'b0000, 4'b0000, 32'd0});
    k = 0;
    seen = 0;
    while (k < 500) begin
      pc    = (k == v.hit) ? v.fin : nonfin(v.fin);
      start = (k == v.poke);
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      k++;
    end
    start = 1'b0;
    if (!seen) begin
      chk({tag, ".done_seen"}, 0, 1);
      return;
    end
    chk({tag, ".latency"}, k, v.e_lat);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pass"}, pass, v.e_pass);
    chk({tag, ".fail_timeout"}, fail_timeout, v.e_to);
    chk({tag, ".fail_mismatch"}, fail_mismatch, v.e_mm);
    chk({tag, ".fail_vec"}, fail_vec, v.e_vec);
    chk({tag, ".fail_idx"}, fail_idx, v.e_idx);
    chk({tag, ".fail_got"}, fail_got, v.e_got);
    chk({tag, ".cycle_count"}, cycle_count, 32'(v.e_cnt));
    repeat (3) @(negedge clk);
    chk({tag, ".hold"}, {done, pass, fail_timeout, fail_mismatch, fail_vec, fail_idx, fail_got,
                         cycle_count},
        {1'b1, v.e_pass, v.e_to, v.e_mm, v.e_vec, v.e_idx, v.e_got, 32'(v.e_cnt)});
  endtask

  task automatic reset_mid_check();
    fin_addr       = 32'h0000_0100;
    timeout_cycles = 32'd0;
    chk_en         = 4'hf;
    chk_addr       = {5'd4, 5'd3, 5'd2, 5'd5};
    chk_exp        = {32'd1, 32'd2, 32'd3, 32'd4};
    pc             = 32'd0;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    pc = 32'h0000_0100;
    @(negedge clk);
    pc = 32'd0;
    chk("rst_mid.busy_pre", busy, 1);
    chk("rst_mid.raddr_pre", rf_raddr, 5'd5);
    chk("rst_mid.count_pre", cycle_count, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", {busy, done, pass, fail_timeout, fail_mismatch, fail_vec, fail_idx,
                            fail_got, cycle_count, rf_raddr}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.idle", {busy, done}, 2'b00);
  endtask

  task automatic random_runs();
    vec_t v;
    logic [4:0] a;
    for (int t = 0; t < 40; t++) begin
      for (int r = 1; r < 32; r++) rf[r] = $urandom;
      rf[0] = 32'd0;
      v.fin  = $urandom;
      v.tmo  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
      v.hit  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60));
      if (v.tmo == 0 && v.hit < 0) v.hit = int'($urandom_range(0, 60));
      v.poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1;
      v.en   = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        a = 5'($urandom_range(0, 31));
        v.addr[i*5 +: 5]   = a;
        v.exp[i*32 +: 32]  = ($urandom_range(0, 3) == 0) ? $urandom : rd(a);
      end
      v.ow_v = 0; v.ow_a = '0; v.ow_d = '0;
      v = model(v);
      run_case(v, $sformatf("rnd%0d", t));
    end
  endtask

  vec_t tbl[6];

  initial begin
    rst_n = 1'b0; start = 1'b0; pc = '0; fin_addr = '0; timeout_cycles = '0;
    chk_en = '0; chk_addr = '0; chk_exp = '0;
    init_rf();

    tbl[0] = mkv(32'hbc, 0, 40, 20, 4'b0011, {5'd0, 5'd0, 5'd2, 5'd10},
                 {32'd0, 32'd0, 32'h0010_0000, 32'h00ff_f05f}, 0, 5'd0, 32'd0,
                 1, 0, 0, 4'b0000, 2'd0, 32'd0, 40, 44);
    tbl[1] = mkv(32'hbc, 0, 5, -1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd10},
                 {32'd0, 32'd0, 32'd0, 32'd3}, 1, 5'd10, 32'd2,
                 0, 0, 1, 4'b0001, 2'd0, 32'd2, 5, AllChk ? 9 : 6);
    tbl[2] = mkv(32'hbc, 100, -1, 50, 4'b0000, '0, '0, 0, 5'd0, 32'd0,
                 0, 1, 0, 4'b0000, 2'd0, 32'd0, 99, 99);
    tbl[3] = mkv(32'hbc, 41, 40, -1, 4'b0000, '0, '0, 0, 5'd0, 32'd0,
                 1, 0, 0, 4'b0000, 2'd0, 32'd0, 40, 44);
    tbl[4] = mkv(32'h8000_0010, 0, 7, -1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
                 {32'h0000_beef, 32'h0100_0003, 32'h0000_dead, 32'h0100_0001}, 0, 5'd0, 32'd0,
                 0, 0, 1, AllChk ? 4'b1010 : 4'b0010, 2'd1, 32'h0010_0000, 7, AllChk ? 11 : 9);
    tbl[5] = mkv(32'h40, 50, 0, -1, 4'b0011, {5'd0, 5'd0, 5'd0, 5'd0},
                 {32'd0, 32'd0, 32'd5, 32'd0}, 0, 5'd0, 32'd0,
                 0, 0, 1, 4'b0010, 2'd1, 32'd0, 0, AllChk ? 4 : 2);

    repeat (2) @(negedge clk);
    chk("reset.outputs", {busy, done, pass, fail_timeout, fail_mismatch, fail_vec, fail_idx,
                          fail_got, cycle_count, rf_raddr}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.idle_after_release", {busy, done, pass}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      init_rf();
      if (tbl[i].ow_v) rf[tbl[i].ow_a] = tbl[i].ow_d;
      run_case(tbl[i], $sformatf("tbl%0d", i));
    end

    init_rf();
    reset_mid_check();
    random_runs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
